// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, oversample ratio and baud divisor.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_STOP  = 3'd3;
  localparam state_t ST_BREAK = 3'd4;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick_o pulse every DIV clocks, re-phased by restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 10000000,
  parameter int BAUD   = 9600
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick_o
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, valid/ready output, framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 10000000,
  parameter int BAUD   = 9600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  logic       sync_p0, sync_p1;
  logic       rx_s;
  state_t     state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       tick;
  logic       restart;
  logic       stop_sample;
  logic       done;
  logic       ferr_hit;

  // Stage p0/p1: two-flop synchronizer, idle-high after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx_i;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_s    = sync_p1;
  assign restart = (state == ST_IDLE) && !rx_s;

  uart_baud_tick #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick_o  (tick)
  );

  assign stop_sample = (state == ST_STOP) && tick && (tick_cnt == 4'd15);
  assign done        = stop_sample && rx_s;
  assign ferr_hit    = stop_sample && !rx_s;

  // Frame FSM: start is confirmed at mid-bit, then every 16 ticks samples one bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            tick_cnt <= 4'd0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= 4'd0;
              bit_cnt  <= 3'd0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt  <= 4'd0;
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ST_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == 4'd15) begin
              tick_cnt <= 4'd0;
              state    <= rx_s ? ST_IDLE : ST_BREAK;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output stage: a byte completing during a handshake replaces the accepted one.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= ferr_hit;
      if (done) begin
        if (!valid_o || ready_i) begin
          data_o  <= shift_reg;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, normal byte, glitch, framing error, overrun, reset mid-frame.
module tb_uart_rx;

  localparam int CLK_HZ = 2000000;
  localparam int BAUD   = 9600;
  localparam int BIT    = 208;
  localparam int GLITCH = 60;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int valid_cycles = 0;
  int valid_rises = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cycles = 0;
  int start_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  logic prev_valid = 1'b0;

  uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc <= cyc + 1;
    prev_valid <= (valid_o === 1'b1);
    if (valid_o === 1'b1) begin
      valid_cycles <= valid_cycles + 1;
      if (!prev_valid) begin
        valid_rises <= valid_rises + 1;
        rise_cyc    <= cyc;
        rise_data   <= data_o;
      end
    end
    if (frame_err_o === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun_o === 1'b1) ovr_cycles <= ovr_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit; the line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    start_cyc = cyc;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      wait_clk(BIT);
    end
    rx_i = stop;
    wait_clk(BIT);
  endtask

  initial begin
    int r0, f0, v0, lat;

    reset = 1'b1;
    rx_i  = 1'b1;
    wait_clk(4);
    @(negedge clock);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 1'b0);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    wait_clk(1);
    reset = 1'b0;
    v0 = valid_cycles;
    f0 = ferr_cnt;
    wait_clk(20000);
    check("quiet_valid", valid_cycles - v0, 0);
    check("quiet_ferr", ferr_cnt - f0, 0);
    check("quiet_ovr", ovr_cycles, 0);
    check("quiet_data", data_o, 8'h00);

    // Normal byte with ready held high.
    v0 = valid_cycles;
    r0 = valid_rises;
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1);
    wait_clk(2 * BIT);
    lat = rise_cyc - start_cyc;
    check("a5_data", rise_data, 8'hA5);
    check("a5_rises", valid_rises - r0, 1);
    check("a5_vcycles", valid_cycles - v0, 1);
    check("a5_latency", (lat >= 9 * BIT + BIT / 2) && (lat <= 9 * BIT + BIT / 2 + BIT / 8), 1'b1);
    check("a5_ferr", ferr_cnt - f0, 0);

    // Short low pulse must not start a frame.
    r0 = valid_rises;
    f0 = ferr_cnt;
    rx_i = 1'b0;
    wait_clk(GLITCH);
    rx_i = 1'b1;
    wait_clk(12 * BIT);
    check("glitch_valid", valid_rises - r0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    send_frame(8'h3C, 1'b1);
    wait_clk(2 * BIT);
    check("3c_data", rise_data, 8'h3C);
    check("3c_rises", valid_rises - r0, 1);

    // Stop bit low, then line held low for three more bit times.
    r0 = valid_rises;
    f0 = ferr_cnt;
    send_frame(8'h00, 1'b0);
    wait_clk(3 * BIT);
    rx_i = 1'b1;
    wait_clk(2 * BIT);
    check("fe_pulses", ferr_cnt - f0, 1);
    check("fe_valid", valid_rises - r0, 0);
    send_frame(8'hFF, 1'b1);
    wait_clk(2 * BIT);
    check("ff_data", rise_data, 8'hFF);
    check("ff_rises", valid_rises - r0, 1);
    check("ff_ferr", ferr_cnt - f0, 1);

    // Overrun: second byte arrives while the first is still unaccepted.
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    wait_clk(2 * BIT);
    check("ov_first_data", data_o, 8'h11);
    check("ov_first_valid", valid_o, 1'b1);
    check("ov_flag_before", overrun_o, 1'b0);
    send_frame(8'h22, 1'b1);
    wait_clk(2 * BIT);
    check("ov_hold_data", data_o, 8'h11);
    check("ov_hold_valid", valid_o, 1'b1);
    check("ov_flag", overrun_o, 1'b1);
    ready_i = 1'b1;
    wait_clk(1);
    check("ov_clear_valid", valid_o, 1'b0);
    check("ov_sticky", overrun_o, 1'b1);

    // Reset during bit 4, held until the stop bit so no new start edge is seen.
    r0 = valid_rises;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        wait_clk(BIT * 11 / 2);
        reset = 1'b1;
        wait_clk(4);
        @(negedge clock);
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_ovr", overrun_o, 1'b0);
        check("mid_rst_data", data_o, 8'h00);
        wait_clk(BIT * 15 / 4 - 4);
        reset = 1'b0;
      end
    join
    wait_clk(2 * BIT);
    check("mid_valid", valid_rises - r0, 0);
    check("mid_ovr", overrun_o, 1'b0);
    send_frame(8'hC3, 1'b1);
    wait_clk(2 * BIT);
    check("c3_data", rise_data, 8'hC3);
    check("c3_rises", valid_rises - r0, 1);
    check("c3_ovr", overrun_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
